// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single register-file write port: ALU vs. load data,
// with a per-register load scoreboard that drives decode stalls.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              load_issue,
  output logic              load_issue_ready,
  input  logic [4:0]        load_rd,
  input  logic [4:0]        rs1_sel,
  input  logic [4:0]        rs2_sel,
  output logic              stall,
  output logic [4:0]        write_register,
  output logic [DATA_W-1:0] write_value
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [NREGS-1:0]  r_busy;
  logic              r_ptr;
  logic [4:0]        r_wr_reg;
  logic [DATA_W-1:0] r_wr_val;

  logic              w_alu_elig;
  logic              w_grant_mem;
  logic              w_grant_alu;
  logic              w_alu_xfer;
  logic              w_mem_xfer;
  logic              w_issue_xfer;
  logic              w_contend;
  logic [NREGS-1:0]  w_busy_next;

  // Architectural, writable register: x1..x(NREGS-1).
  function automatic logic rd_valid(input logic [4:0] rd);
    return (rd != 5'd0) && (int'({27'd0, rd}) < NREGS);
  endfunction

  function automatic logic busy_of(input logic [NREGS-1:0] busy, input logic [4:0] rd);
    return rd_valid(rd) ? busy[rd[IDX_W-1:0]] : 1'b0;
  endfunction

  // Grant selection, handshakes and decode stall.
  always_comb begin
    w_alu_elig       = alu_valid && !busy_of(r_busy, alu_rd);
    w_contend        = w_alu_elig && mem_valid;
    w_grant_mem      = mem_valid && (!w_alu_elig || !r_ptr);
    w_grant_alu      = w_alu_elig && !w_grant_mem;
    alu_ready        = w_grant_alu;
    mem_ready        = w_grant_mem;
    w_alu_xfer       = w_grant_alu;
    w_mem_xfer       = w_grant_mem;
    load_issue_ready = !busy_of(r_busy, load_rd);
    w_issue_xfer     = load_issue && load_issue_ready;
    stall = (rd_valid(rs1_sel) && (busy_of(r_busy, rs1_sel) || (rs1_sel == r_wr_reg))) ||
            (rd_valid(rs2_sel) && (busy_of(r_busy, rs2_sel) || (rs2_sel == r_wr_reg)));
  end

  // Scoreboard next state: a same-edge issue wins over the load's own clear.
  always_comb begin
    w_busy_next = r_busy;
    if (w_mem_xfer && rd_valid(mem_rd)) begin
      w_busy_next[mem_rd[IDX_W-1:0]] = 1'b0;
    end else begin
      w_busy_next = w_busy_next;
    end
    if (w_issue_xfer && rd_valid(load_rd)) begin
      w_busy_next[load_rd[IDX_W-1:0]] = 1'b1;
    end else begin
      w_busy_next = w_busy_next;
    end
  end

  // Registered write port, round-robin pointer and scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= '0;
      r_ptr    <= 1'b0;
      r_wr_reg <= 5'd0;
      r_wr_val <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_contend) begin
        r_ptr <= w_grant_mem;
      end
      if (w_alu_xfer) begin
        r_wr_reg <= rd_valid(alu_rd) ? alu_rd : 5'd0;
        r_wr_val <= alu_data;
      end else if (w_mem_xfer) begin
        r_wr_reg <= rd_valid(mem_rd) ? mem_rd : 5'd0;
        r_wr_val <= mem_data;
      end else begin
        r_wr_reg <= 5'd0;
      end
    end
  end

  assign write_register = r_wr_reg;
  assign write_value    = r_wr_val;

endmodule
